alu_issue_scheduler: RTL

//  Issue-stage scheduler between the reservation station (RS) and the NUM_ALU ALU lanes.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/rr_pick_first.sv | 46 ++++
 rtl/alu_issue_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage.
//   - Lane-data field widths (OPT_W, DATA_W, DR_W)
//   - Optype encodings OPT_ADD (1) .. OPT_SW (10); 7..10 are memory ops
//   - is_valid_op(): optype may be issued at all
//   - is_mem_op():   optype must go to the memory lane and needs LSQ space
package alu_pkg;

  localparam int OPT_W  = 4;
  localparam int DATA_W = 32;
  localparam int DR_W   = 6;

  localparam logic [OPT_W-1:0] OPT_ADD  = 4'd1;
  localparam logic [OPT_W-1:0] OPT_SUB  = 4'd2;
  localparam logic [OPT_W-1:0] OPT_AND  = 4'd3;
  localparam logic [OPT_W-1:0] OPT_OR   = 4'd4;
  localparam logic [OPT_W-1:0] OPT_XOR  = 4'd5;
  localparam logic [OPT_W-1:0] OPT_ADDI = 4'd6;
  localparam logic [OPT_W-1:0] OPT_LW   = 4'd7;
  localparam logic [OPT_W-1:0] OPT_LB   = 4'd8;
  localparam logic [OPT_W-1:0] OPT_SB   = 4'd9;
  localparam logic [OPT_W-1:0] OPT_SW   = 4'd10;

  function automatic logic is_valid_op(input logic [OPT_W-1:0] op);
    return (op >= OPT_ADD) && (op <= OPT_SW);
  endfunction

  function automatic logic is_mem_op(input logic [OPT_W-1:0] op);
    return (op >= OPT_LW) && (op <= OPT_SW);
  endfunction

endpackage

// File: rtl/rr_pick_first.sv
// Rotating-priority first-pick: returns the first set request at or after
// ptr, wrapping around modulo N.
//   req   in   N      request vector
//   ptr   in   log2N  highest-priority index
//   grant out  N      one-hot winner (zero when found=0)
//   idx   out  log2N  winner index
//   found out  1      any request set
module rr_pick_first #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [N-1:0] rot;
  logic [W-1:0] enc;

  // Rotate so that entry ptr lands on bit 0; W-bit index sum wraps mod N.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) rot[i] = req[W'(i) + ptr];
  end

  always_comb begin
    enc   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc   = W'(i);
        found = 1'b1;
      end
    end
  end

  assign idx = enc + ptr;

  always_comb begin
    grant = '0;
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Issue-stage scheduler: picks up to NUM_ALU ready RS entries per cycle in
// round-robin order and loads them into per-lane issue registers.
//   clk, rstn            clock / async active-low reset
//   flush, cdb_stall     squash (clears lanes + pointer) / freeze
//   lsq_ready            memory op may issue this cycle
//   rs_req, rs_optype, rs_src1, rs_src2, rs_imm, rs_dr   RS entry inputs
//   rs_grant             combinational grant pulse back to the RS
//   alu_number, alu_optype, alu_src1, alu_src2, alu_imm, alu_dr   lane regs
//   rr_ptr               current highest-priority entry
module alu_issue_scheduler
  import alu_pkg::*;
#(
  parameter  int NUM_RS   = 8,
  parameter  int NUM_ALU  = 3,
  parameter  int MEM_LANE = 0,
  localparam int PTR_W    = $clog2(NUM_RS),
  localparam int LANE_W   = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
  input  logic                      cdb_stall,
  input  logic                      lsq_ready,
  input  logic [NUM_RS-1:0]         rs_req,
  input  logic [NUM_RS*OPT_W-1:0]   rs_optype,
  input  logic [NUM_RS*DATA_W-1:0]  rs_src1,
  input  logic [NUM_RS*DATA_W-1:0]  rs_src2,
  input  logic [NUM_RS*DATA_W-1:0]  rs_imm,
  input  logic [NUM_RS*DR_W-1:0]    rs_dr,
  output logic [NUM_RS-1:0]         rs_grant,
  output logic [NUM_ALU-1:0]        alu_number,
  output logic [NUM_ALU*OPT_W-1:0]  alu_optype,
  output logic [NUM_ALU*DATA_W-1:0] alu_src1,
  output logic [NUM_ALU*DATA_W-1:0] alu_src2,
  output logic [NUM_ALU*DATA_W-1:0] alu_imm,
  output logic [NUM_ALU*DR_W-1:0]   alu_dr,
  output logic [PTR_W-1:0]          rr_ptr
);

  logic [NUM_RS-1:0] elig_alu;
  logic [NUM_RS-1:0] elig_mem;

  always_comb begin
    elig_alu = '0;
    elig_mem = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (rs_req[i] && is_valid_op(rs_optype[i*OPT_W +: OPT_W])) begin
        if (is_mem_op(rs_optype[i*OPT_W +: OPT_W])) elig_mem[i] = 1'b1;
        else                                         elig_alu[i] = 1'b1;
      end
    end
  end

  // Only the first memory op in scan order matters; the rest wait.
  logic [NUM_RS-1:0] mem_oh;
  logic [PTR_W-1:0]  mem_idx;
  logic              mem_found;

  rr_pick_first #(.N(NUM_RS)) u_pick_mem (
    .req  (elig_mem),
    .ptr  (rr_ptr),
    .grant(mem_oh),
    .idx  (mem_idx),
    .found(mem_found)
  );

  // Cascade: pick k sees the non-memory requests minus picks 0..k-1.
  logic [NUM_RS-1:0]  pick_oh  [NUM_ALU];
  logic [PTR_W-1:0]   pick_idx [NUM_ALU];
  logic [NUM_ALU-1:0] pick_vld;

  for (genvar k = 0; k < NUM_ALU; k++) begin : g_pick
    logic [NUM_RS-1:0] req_in;
    if (k == 0) begin : g_head
      assign req_in = elig_alu;
    end else begin : g_tail
      assign req_in = g_pick[k-1].req_in & ~pick_oh[k-1];
    end
    rr_pick_first #(.N(NUM_RS)) u_pick (
      .req  (req_in),
      .ptr  (rr_ptr),
      .grant(pick_oh[k]),
      .idx  (pick_idx[k]),
      .found(pick_vld[k])
    );
  end

  // When a memory op is pending, MEM_LANE is held for it even if the LSQ is
  // full, and the non-memory picks shift onto the remaining lanes.
  logic [NUM_ALU-1:0] lane_vld;
  logic [PTR_W-1:0]   lane_sel [NUM_ALU];
  logic [NUM_RS-1:0]  grant_raw;
  logic [LANE_W-1:0]  slot;

  always_comb begin
    lane_vld  = '0;
    grant_raw = '0;
    slot      = '0;
    for (int l = 0; l < NUM_ALU; l++) lane_sel[l] = '0;
    for (int l = 0; l < NUM_ALU; l++) begin
      if (mem_found && (l == MEM_LANE)) begin
        if (lsq_ready) begin
          lane_vld[l] = 1'b1;
          lane_sel[l] = mem_idx;
          grant_raw   = grant_raw | mem_oh;
        end
      end else begin
        slot = (mem_found && (l > MEM_LANE)) ? LANE_W'(l - 1) : LANE_W'(l);
        if (pick_vld[slot]) begin
          lane_vld[l] = 1'b1;
          lane_sel[l] = pick_idx[slot];
          grant_raw   = grant_raw | pick_oh[slot];
        end
      end
    end
  end

  // Next pointer: one past the last granted entry in scan order.
  logic [PTR_W-1:0] ptr_next;

  always_comb begin
    ptr_next = rr_ptr;
    for (int off = 0; off < NUM_RS; off++) begin
      if (grant_raw[rr_ptr + PTR_W'(off)]) ptr_next = rr_ptr + PTR_W'(off + 1);
    end
  end

  assign rs_grant = (rstn && !flush && !cdb_stall) ? grant_raw : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alu_number <= '0;
      alu_optype <= '0;
      alu_src1   <= '0;
      alu_src2   <= '0;
      alu_imm    <= '0;
      alu_dr     <= '0;
      rr_ptr     <= '0;
    end else if (flush) begin
      alu_number <= '0;
      rr_ptr     <= '0;
    end else if (!cdb_stall) begin
      alu_number <= lane_vld;
      rr_ptr     <= ptr_next;
      for (int l = 0; l < NUM_ALU; l++) begin
        if (lane_vld[l]) begin
          alu_optype[l*OPT_W +: OPT_W]   <= rs_optype[lane_sel[l]*OPT_W +: OPT_W];
          alu_src1[l*DATA_W +: DATA_W]   <= rs_src1[lane_sel[l]*DATA_W +: DATA_W];
          alu_src2[l*DATA_W +: DATA_W]   <= rs_src2[lane_sel[l]*DATA_W +: DATA_W];
          alu_imm[l*DATA_W +: DATA_W]    <= rs_imm[lane_sel[l]*DATA_W +: DATA_W];
          alu_dr[l*DR_W +: DR_W]         <= rs_dr[lane_sel[l]*DR_W +: DR_W];
        end
      end
    end
  end

endmodule
